// File: rtl/ad7276_reader.sv
// SPI master for the AD7276 12-bit ADC: runs back-to-back 16-bit frames while en is high
// and presents each 12-bit sample with a one-cycle strobe and a leading-zero error flag.
//
// state | meaning
// IDLE  | csn/sclk high, waiting for en
// CONV  | csn low, 16 sclk periods, shifting sdata in on each sclk rise
// QUIET | csn/sclk high for QUIET_CYCLES between frames
module ad7276_reader #(
   parameter int CLK_DIV      = 1,
   parameter int QUIET_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        ad7276_csn,
   output logic        ad7276_sclk,
   input  logic        ad7276_sdata,
   output logic        adc_data_en,
   output logic [11:0] adc_data,
   output logic        adc_frame_err
);

   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam int QW = $clog2(QUIET_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt, div_nxt;
   logic [3:0]    bit_cnt, bit_nxt;
   logic [QW-1:0] q_cnt, q_nxt;
   logic [14:0]   shift, shift_nxt;
   logic [15:0]   frame;
   logic          csn_nxt, sclk_nxt, data_en_nxt, err_nxt;
   logic [11:0]   data_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         ad7276_csn    <= 1'b1;
         ad7276_sclk   <= 1'b1;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         q_cnt         <= '0;
         shift         <= '0;
         adc_data_en   <= 1'b0;
         adc_data      <= '0;
         adc_frame_err <= 1'b0;
      end else begin
         state         <= state_nxt;
         ad7276_csn    <= csn_nxt;
         ad7276_sclk   <= sclk_nxt;
         div_cnt       <= div_nxt;
         bit_cnt       <= bit_nxt;
         q_cnt         <= q_nxt;
         shift         <= shift_nxt;
         adc_data_en   <= data_en_nxt;
         adc_data      <= data_nxt;
         adc_frame_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      csn_nxt     = ad7276_csn;
      sclk_nxt    = ad7276_sclk;
      div_nxt     = div_cnt;
      bit_nxt     = bit_cnt;
      q_nxt       = q_cnt;
      shift_nxt   = shift;
      data_en_nxt = 1'b0;
      data_nxt    = adc_data;
      err_nxt     = adc_frame_err;
      // full frame including the bit arriving on this sclk rise
      frame       = {shift, ad7276_sdata};

      case (state)
         IDLE: begin
            csn_nxt  = 1'b1;
            sclk_nxt = 1'b1;
            if (en) begin
               state_nxt = CONV;
               csn_nxt   = 1'b0;
               div_nxt   = '0;
               bit_nxt   = '0;
            end
         end
         CONV: begin
            if (div_cnt == DW'(CLK_DIV - 1)) begin
               div_nxt  = '0;
               sclk_nxt = ~ad7276_sclk;
               if (!ad7276_sclk) begin
                  shift_nxt = frame[14:0];
                  bit_nxt   = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd15) begin
                     csn_nxt     = 1'b1;
                     data_en_nxt = 1'b1;
                     data_nxt    = frame[13:2];
                     err_nxt     = (frame[15:14] != 2'b00);
                     q_nxt       = '0;
                     state_nxt   = QUIET;
                  end
               end
            end else begin
               div_nxt = div_cnt + DW'(1);
            end
         end
         QUIET: begin
            csn_nxt  = 1'b1;
            sclk_nxt = 1'b1;
            if (q_cnt == QW'(QUIET_CYCLES - 1)) begin
               if (en) begin
                  state_nxt = CONV;
                  csn_nxt   = 1'b0;
                  div_nxt   = '0;
                  bit_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               q_nxt = q_cnt + QW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
